// File: rtl/dsp_mac_sequencer.sv
// Control sequencer for a DSP48A1-style MAC slice: fetches operand beats and
// drives the slice stage enables, P clear and accumulate select. Carries no data.
module dsp_mac_sequencer #(
  parameter int LEN_W = 8,
  parameter int AREG  = 1,
  parameter int MREG  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             abort,
  output logic             ce_a,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_p,
  output logic             acc_sel,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] term_cnt
);

  localparam int DEPTH = AREG + MREG;
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_CLEAR, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, term_cnt_reg;
  logic             cmd_accept, op_open, op_accept, abort_act, last_beat, pending;
  logic [DEPTH:0]   tok_v, tok_f;

  assign cmd_accept = cmd_valid && (state_reg == S_IDLE);
  assign abort_act  = abort && (state_reg inside {S_LOAD, S_DRAIN, S_CLEAR});
  // An abort in the same cycle withdraws op_ready, so a concurrent beat is dropped.
  assign op_open    = (state_reg == S_LOAD) && (term_cnt_reg != len_reg) && !abort;
  assign op_accept  = op_valid && op_open;
  assign last_beat  = op_accept && ((term_cnt_reg + CNT_ONE) == len_reg);

  // Token pipe: stage 0 is the beat accepted this cycle, stage k is k cycles old.
  assign tok_v[0] = op_accept;
  assign tok_f[0] = (term_cnt_reg == '0);

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_pipe
      logic v_reg, f_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg <= 1'b0;
          f_reg <= 1'b0;
        end else if (abort_act) begin
          v_reg <= 1'b0;
          f_reg <= 1'b0;
        end else begin
          v_reg <= tok_v[gi-1];
          f_reg <= tok_f[gi-1];
        end
      end
      assign tok_v[gi] = v_reg;
      assign tok_f[gi] = f_reg;
    end
  endgenerate

  // Tokens short of the final stage mean another ce_p cycle is still coming.
  always_comb begin
    pending = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      pending = pending | tok_v[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg      <= '0;
      term_cnt_reg <= '0;
    end else if (cmd_accept) begin
      len_reg      <= cmd_len;
      term_cnt_reg <= '0;
    end else if (op_accept) begin
      term_cnt_reg <= term_cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_accept) begin
          state_next = (cmd_len == '0) ? S_CLEAR : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_act) begin
          state_next = S_IDLE;
        end else if (last_beat) begin
          state_next = (DEPTH == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_act) begin
          state_next = S_IDLE;
        end else if (!pending) begin
          state_next = S_DONE;
        end
      end
      S_CLEAR: state_next = abort_act ? S_IDLE : S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == S_IDLE);
    op_ready  = op_open;
    ce_a      = op_accept;
    ce_m      = tok_v[AREG] && !abort_act;
    ce_p      = tok_v[DEPTH] && !abort_act;
    acc_sel   = tok_v[DEPTH] && !abort_act && !tok_f[DEPTH];
    rst_p     = (state_reg == S_CLEAR) || abort_act;
    busy      = (state_reg != S_IDLE);
    done      = (state_reg == S_DONE);
    term_cnt  = term_cnt_reg;
  end

endmodule
